// File: rtl/conv_window_sched.sv
// Window scheduler for a 3x3 line-buffered convolution: paces the input stream into the
// shared delay lines and flags each position where a full window is available.
module conv_window_sched #(
  parameter int WIDTH     = 64,
  parameter int MAX_DEPTH = 128,
  parameter int DIM_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       cfg_cin_groups,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             lb_en,
  output logic [7:0]       lb_delay_depth,
  output logic [WIDTH-1:0] lb_din,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [7:0]       m_grp,
  output logic [DIM_W-1:0] m_col,
  output logic [DIM_W-1:0] m_row,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       r_state;
  logic [7:0]       r_groups;
  logic [DIM_W-1:0] r_width;
  logic [DIM_W-1:0] r_height;
  logic [7:0]       r_grp;
  logic [DIM_W-1:0] r_col;
  logic [DIM_W-1:0] r_row;
  logic [7:0]       r_depth;
  logic             r_m_valid;
  logic             r_m_last;
  logic [7:0]       r_m_grp;
  logic [DIM_W-1:0] r_m_col;
  logic [DIM_W-1:0] r_m_row;
  logic             r_done;
  logic             r_cfg_err;

  logic w_cfg_ok;
  logic w_accept;
  logic w_grp_wrap;
  logic w_col_wrap;
  logic w_row_last;
  logic w_is_last;
  logic w_window;

  assign w_cfg_ok   = (cfg_cin_groups != 8'd0) && (int'(cfg_cin_groups) <= MAX_DEPTH) &&
                      (cfg_width >= DIM_W'(3)) && (cfg_height >= DIM_W'(3));
  assign w_grp_wrap = (r_grp == r_groups - 8'd1);
  assign w_col_wrap = (r_col == r_width - DIM_W'(1));
  assign w_row_last = (r_row == r_height - DIM_W'(1));
  assign w_is_last  = w_grp_wrap && w_col_wrap && w_row_last;
  assign w_window   = (r_row >= DIM_W'(2)) && (r_col >= DIM_W'(2));

  // Upstream only moves when the window strobe slot is free or being drained this cycle.
  assign s_ready = (r_state == S_STREAM) && (!r_m_valid || m_ready);
  assign w_accept = s_valid && s_ready;

  assign lb_en          = w_accept;
  assign lb_din         = s_data;
  assign lb_delay_depth = r_depth;
  assign m_valid        = r_m_valid;
  assign m_last         = r_m_last;
  assign m_grp          = r_m_grp;
  assign m_col          = r_m_col;
  assign m_row          = r_m_row;
  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign cfg_err        = r_cfg_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_groups  <= 8'd0;
      r_width   <= '0;
      r_height  <= '0;
      r_grp     <= 8'd0;
      r_col     <= '0;
      r_row     <= '0;
      r_depth   <= 8'd0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_groups <= cfg_cin_groups;
            r_width  <= cfg_width;
            r_height <= cfg_height;
            if (w_cfg_ok) begin
              r_state <= S_STREAM;
              r_depth <= cfg_cin_groups;
              r_grp   <= 8'd0;
              r_col   <= '0;
              r_row   <= '0;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (w_accept) begin
            if (w_grp_wrap) begin
              r_grp <= 8'd0;
              if (w_col_wrap) begin
                r_col <= '0;
                r_row <= r_row + DIM_W'(1);
              end else begin
                r_col <= r_col + DIM_W'(1);
              end
            end else begin
              r_grp <= r_grp + 8'd1;
            end
            if (w_is_last) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!r_m_valid || m_ready) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobe register sits one cycle behind the accept, aligned with the delay-line output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_grp   <= 8'd0;
      r_m_col   <= '0;
      r_m_row   <= '0;
    end else if (w_accept && w_window) begin
      r_m_valid <= 1'b1;
      r_m_last  <= w_is_last;
      r_m_grp   <= r_grp;
      r_m_col   <= r_col;
      r_m_row   <= r_row;
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else begin
      r_m_valid <= r_m_valid;
      r_m_last  <= r_m_last;
    end
  end

endmodule
